cam_config_sequencer: RTL and testbench

CAM_CONFIG_SEQUENCER -- requirements
Module: cam_config_sequencer

---
 rtl/cam_cfg_pkg.sv | 43 ++++
 rtl/sccb_write_master.sv | 83 ++++++++
 rtl/cam_config_sequencer.sv | 119 +++++++++++
 tb/tb_cam_config_sequencer.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cam_cfg_pkg.sv
// Shared types, constants and the register table for the camera configuration
// sequencer. Build option: CAM_CFG_TEST_PATTERN_EN adds the colour-bar test
// pattern writes just ahead of the end-of-table entry.
package cam_cfg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_WRITE = 3'd2,
    ST_GAP   = 3'd3,
    ST_DELAY = 3'd4,
    ST_DONE  = 3'd5
  } cam_cfg_state_e;

  // {reg_addr[15:8], reg_data[7:0]}
  typedef logic [15:0] cam_cfg_entry_t;

  localparam logic [7:0]     SCCB_DEV_ID = 8'h42;
  localparam cam_cfg_entry_t ENTRY_END   = 16'hFFFF;
  localparam cam_cfg_entry_t ENTRY_DELAY = 16'hFFF0;
  localparam int unsigned    ROM_DEPTH   = 16;

  // Table contents; unused slots read as end-of-table.
  function automatic cam_cfg_entry_t cam_cfg_rom(input logic [7:0] idx);
    cam_cfg_entry_t e;
    case (idx)
      8'd0:    e = 16'h1280;   // COM7: soft reset
      8'd1:    e = ENTRY_DELAY; // let the sensor settle after reset
      8'd2:    e = 16'h1204;   // COM7: RGB output
      8'd3:    e = 16'h1100;   // CLKRC: internal clock prescaler
      8'd4:    e = 16'h0C00;   // COM3: defaults
      8'd5:    e = 16'h3E00;   // COM14: no scaling
      8'd6:    e = 16'h4010;   // COM15: RGB565
`ifdef CAM_CFG_TEST_PATTERN_EN
      8'd7:    e = 16'h70BA;   // colour bar test pattern, x
      8'd8:    e = 16'h71B5;   // colour bar test pattern, y
`endif
      default: e = ENTRY_END;
    endcase
    return e;
  endfunction

endpackage

// File: rtl/sccb_write_master.sv
// Bit-level SCCB 3-phase write: START, device ID / address / data phases
// (8 bits MSB first plus one released don't-care bit each), STOP.
// The line is open-drain: a logical 1 is signalled by releasing SIOD.
module sccb_write_master
  import cam_cfg_pkg::*;
#(
  parameter int unsigned QTR = 1
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       req,
  input  logic [7:0] addr,
  input  logic [7:0] data,
  output logic       ack,
  output logic       sioc,
  output logic       siod_oe
);

  localparam int unsigned    QW        = (QTR > 1) ? $clog2(QTR) : 1;
  localparam logic [QW-1:0]  QLAST     = QW'(QTR - 1);
  localparam logic [4:0]     SLOT_STOP = 5'd28;  // slot 0 = START, 1..27 = bits

  logic          active;
  logic [QW-1:0] qcnt;
  logic [1:0]    qtr;
  logic [4:0]    slot;
  logic [26:0]   frame;
  logic          qtr_end;
  logic          slot_end;

  // Quarter/slot boundary detection and end-of-STOP acknowledge
  always_comb begin
    qtr_end  = (qcnt == QLAST);
    slot_end = qtr_end && (qtr == 2'd3);
    ack      = active && (slot == SLOT_STOP) && slot_end;
  end

  // Transaction timing: cycles within a quarter, quarters within a slot, slots
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      active <= 1'b0;
      qcnt   <= '0;
      qtr    <= '0;
      slot   <= '0;
      frame  <= '0;
    end else if (!active) begin
      if (req) begin
        active <= 1'b1;
        frame  <= {SCCB_DEV_ID, 1'b1, addr, 1'b1, data, 1'b1};
        qcnt   <= '0;
        qtr    <= '0;
        slot   <= '0;
      end
    end else begin
      qcnt <= qtr_end ? '0 : qcnt + QW'(1);
      if (qtr_end) qtr <= qtr + 2'd1;
      if (slot_end) begin
        if (slot == SLOT_STOP) active <= 1'b0;
        else                   slot   <= slot + 5'd1;
        if (slot != 5'd0) frame <= {frame[25:0], 1'b1};
      end
    end
  end

  // Bus levels for the current slot/quarter; idle bus is SIOC high, SIOD released
  always_comb begin
    sioc    = 1'b1;
    siod_oe = 1'b0;
    if (active) begin
      if (slot == 5'd0) begin
        sioc    = (qtr < 2'd2);
        siod_oe = 1'b1;
      end else if (slot == SLOT_STOP) begin
        sioc    = (qtr != 2'd0);
        siod_oe = (qtr < 2'd2);
      end else begin
        sioc    = (qtr == 2'd1) || (qtr == 2'd2);
        siod_oe = ~frame[26];
      end
    end
  end

endmodule

// File: rtl/cam_config_sequencer.sv
// Walks the configuration table after a start pulse, issuing one SCCB write
// per entry, waiting on delay entries, and parking in DONE at the table end.
// Build option: CAM_CFG_TEST_PATTERN_EN (see cam_cfg_pkg).
module cam_config_sequencer
  import cam_cfg_pkg::*;
#(
  parameter int unsigned CLK_HZ   = 100_000_000,
  parameter int unsigned SCCB_HZ  = 100_000,
  parameter int unsigned DELAY_MS = 10
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       start_i,
  output logic       sioc_o,
  output logic       siod_o,
  output logic       siod_oe_o,
  output logic       busy_o,
  output logic       done_o,
  output logic [7:0] index_o
);

  localparam int unsigned QTR        = CLK_HZ / (4 * SCCB_HZ);
  localparam logic [63:0] DELAY_RAW  = 64'(DELAY_MS) * 64'(CLK_HZ) / 64'd1000;
  localparam logic [31:0] DELAY_CYC  = (DELAY_RAW == 64'd0) ? 32'd1 : DELAY_RAW[31:0];
  localparam logic [31:0] DELAY_LOAD = DELAY_CYC - 32'd1;
  localparam logic [31:0] GAP_LOAD   = 32'(4 * QTR) - 32'd1;

  if (QTR < 1) begin : g_qtr_check
    $error("cam_config_sequencer: CLK_HZ/(4*SCCB_HZ) must be at least 1");
  end

  cam_cfg_state_e state, state_d;
  logic [7:0]     index, index_d;
  logic [31:0]    wait_cnt, wait_cnt_d;
  cam_cfg_entry_t entry_q;
  logic           is_end, is_delay, wr_req, wr_ack;

  // Next-state logic; the table word for index_d is registered on the same
  // edge so it is valid throughout the single FETCH cycle.
  always_comb begin
    state_d    = state;
    index_d    = index;
    wait_cnt_d = wait_cnt;
    is_end     = (32'(index) >= ROM_DEPTH) || (entry_q == ENTRY_END);
    is_delay   = (entry_q == ENTRY_DELAY);
    wr_req     = (state == ST_FETCH) && !is_end && !is_delay;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (start_i) begin
          state_d = ST_FETCH;
          index_d = '0;
        end
      end
      ST_FETCH: begin
        if (is_end) begin
          state_d = ST_DONE;
        end else if (is_delay) begin
          state_d    = ST_DELAY;
          wait_cnt_d = DELAY_LOAD;
        end else begin
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (wr_ack) begin
          state_d    = ST_GAP;
          wait_cnt_d = GAP_LOAD;
        end
      end
      ST_GAP, ST_DELAY: begin
        if (wait_cnt == '0) begin
          state_d = ST_FETCH;
          index_d = index + 8'd1;
        end else begin
          wait_cnt_d = wait_cnt - 32'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Sequencer state, table index, wait counter and table read register
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state    <= ST_IDLE;
      index    <= '0;
      wait_cnt <= '0;
      entry_q  <= '0;
    end else begin
      state    <= state_d;
      index    <= index_d;
      wait_cnt <= wait_cnt_d;
      entry_q  <= cam_cfg_rom(index_d);
    end
  end

  sccb_write_master #(
    .QTR(QTR)
  ) u_sccb (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .req     (wr_req),
    .addr    (entry_q[15:8]),
    .data    (entry_q[7:0]),
    .ack     (wr_ack),
    .sioc    (sioc_o),
    .siod_oe (siod_oe_o)
  );

  // Status outputs decoded from the sequencer state
  always_comb begin
    busy_o  = (state == ST_FETCH) || (state == ST_WRITE) ||
              (state == ST_GAP)   || (state == ST_DELAY);
    done_o  = (state == ST_DONE);
    index_o = index;
    siod_o  = 1'b0;
  end

endmodule

// File: tb/tb_cam_config_sequencer.sv
// Self-checking bench for cam_config_sequencer. A timeline model derives every
// output from the table and the bus rules; a bus decoder recovers the written
// bytes from SIOC/SIOD_OE; directed literal checks pin the model.
`timescale 1ns/1ps
module tb_cam_config_sequencer;

  localparam int unsigned CLK_HZ   = 40_000;
  localparam int unsigned SCCB_HZ  = 10_000;
  localparam int unsigned DELAY_MS = 1;
  localparam int unsigned QTR      = CLK_HZ / (4 * SCCB_HZ);   // 1
  localparam int unsigned DCYC     = DELAY_MS * CLK_HZ / 1000; // 40
  localparam int unsigned DEPTH    = 16;
`ifdef CAM_CFG_TEST_PATTERN_EN
  localparam int unsigned END_IDX  = 9;
  localparam int unsigned WR_CNT   = 8;
`else
  localparam int unsigned END_IDX  = 7;
  localparam int unsigned WR_CNT   = 6;
`endif

  logic       clk_i   = 1'b0;
  logic       reset_i = 1'b1;
  logic       start_i = 1'b0;
  logic       sioc_o, siod_o, siod_oe_o, busy_o, done_o;
  logic [7:0] index_o;

  int n_checks = 0;
  int n_errors = 0;

  cam_config_sequencer #(
    .CLK_HZ  (CLK_HZ),
    .SCCB_HZ (SCCB_HZ),
    .DELAY_MS(DELAY_MS)
  ) dut (
    .clk_i    (clk_i),
    .reset_i  (reset_i),
    .start_i  (start_i),
    .sioc_o   (sioc_o),
    .siod_o   (siod_o),
    .siod_oe_o(siod_oe_o),
    .busy_o   (busy_o),
    .done_o   (done_o),
    .index_o  (index_o)
  );

  always #5 clk_i = ~clk_i;

  logic [15:0] tab [DEPTH];
  logic [23:0] wr_list [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  function automatic int unsigned end_index();
    for (int unsigned i = 0; i < DEPTH; i++)
      if (tab[i] == 16'hFFFF) return i;
    return DEPTH;
  endfunction

  function automatic int unsigned seg_len(input int unsigned i);
    if (tab[i] == 16'hFFF0) return 1 + DCYC;
    return 1 + 116 * QTR + 4 * QTR;
  endfunction

  function automatic int unsigned run_len();
    int unsigned acc = 0;
    for (int unsigned i = 0; i < end_index(); i++) acc += seg_len(i);
    return acc + 1;
  endfunction

  task automatic wave(input int unsigned o, input logic [15:0] e,
                      output logic sioc, output logic oe);
    int unsigned slot = o / 4;
    int unsigned q    = o % 4;
    int unsigned k, b;
    logic [7:0] byt;
    if (slot == 0) begin
      sioc = (q < 2); oe = 1'b1;
    end else if (slot == 28) begin
      sioc = (q != 0); oe = (q < 2);
    end else begin
      k = slot - 1;
      b = k % 9;
      case (k / 9)
        0:       byt = 8'h42;
        1:       byt = e[15:8];
        default: byt = e[7:0];
      endcase
      sioc = (q == 1) || (q == 2);
      oe   = (b == 8) ? 1'b0 : !byt[7-b];
    end
  endtask

  task automatic model_at(input int unsigned t, output int unsigned idx,
                          output logic sioc, output logic oe);
    int unsigned acc = 0;
    sioc = 1'b1; oe = 1'b0; idx = end_index();
    for (int unsigned i = 0; i < end_index(); i++) begin
      if (t < acc + seg_len(i)) begin
        idx = i;
        if (tab[i] != 16'hFFF0 && t >= acc + 1 && t < acc + 1 + 116 * QTR)
          wave((t - acc - 1) / QTR, tab[i], sioc, oe);
        return;
      end
      acc += seg_len(i);
    end
  endtask

  bit          m_run  = 1'b0;
  bit          m_done = 1'b0;
  int unsigned m_t    = 0;

  always @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      m_run <= 1'b0; m_done <= 1'b0; m_t <= 0;
    end else if (m_run) begin
      if (m_t == run_len() - 1) begin m_run <= 1'b0; m_done <= 1'b1; end
      else m_t <= m_t + 1;
    end else if (start_i) begin
      m_run <= 1'b1; m_done <= 1'b0; m_t <= 0;
    end
  end

  // per-cycle compare against the model
  always @(negedge clk_i) begin
    int unsigned e_idx;
    logic e_sioc, e_oe;
    if (m_run) model_at(m_t, e_idx, e_sioc, e_oe);
    else begin
      e_idx = m_done ? end_index() : 0; e_sioc = 1'b1; e_oe = 1'b0;
    end
    chk("busy",    busy_o,    m_run);
    chk("done",    done_o,    m_done);
    chk("index",   index_o,   e_idx);
    chk("sioc",    sioc_o,    e_sioc);
    chk("siod_oe", siod_oe_o, e_oe);
    chk("siod",    siod_o,    0);
  end

  // ---------------- bus decoder ----------------
  logic        p_sioc = 1'b1;
  logic        p_oe   = 1'b0;
  logic [27:0] sr     = '0;
  int unsigned nbits  = 0;
  int unsigned wr_ptr = 0;
  logic [23:0] dec_q [$];

  always @(negedge clk_i) begin
    if (reset_i) begin
      p_sioc <= 1'b1; p_oe <= 1'b0; nbits <= 0;
    end else begin
      if (m_run && m_t == 0) wr_ptr <= 0;
      if (p_sioc && sioc_o && !p_oe && siod_oe_o) begin
        nbits <= 0;
      end else if (!p_sioc && sioc_o) begin
        sr    <= {sr[26:0], ~siod_oe_o};
        nbits <= nbits + 1;
      end else if (p_sioc && sioc_o && p_oe && !siod_oe_o) begin
        chk("frame_bits", nbits, 28);
        chk("dc_bits", {sr[19], sr[10], sr[1], sr[0]}, 4'b1110);
        dec_q.push_back({sr[27:20], sr[18:11], sr[9:2]});
        chk("wr_bytes", {sr[27:20], sr[18:11], sr[9:2]},
            (wr_ptr < wr_list.size()) ? wr_list[wr_ptr] : 24'hFFFFFF);
        if (!(m_run && m_t == 0)) wr_ptr <= wr_ptr + 1;
      end
      p_sioc <= sioc_o; p_oe <= siod_oe_o;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic pulse_start();
    @(negedge clk_i); #1 start_i = 1'b1;
    @(negedge clk_i); #1 start_i = 1'b0;
  endtask

  task automatic hit_reset();
    @(negedge clk_i); #1 reset_i = 1'b1;
    #1;
    chk("rst_sioc",  sioc_o,    1);
    chk("rst_oe",    siod_oe_o, 0);
    chk("rst_busy",  busy_o,    0);
    chk("rst_done",  done_o,    0);
    chk("rst_index", index_o,   0);
    @(negedge clk_i); #1 reset_i = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int unsigned k = 0;
    while (done_o !== 1'b1 && k < 4000) begin @(negedge clk_i); k++; end
    chk(name, done_o, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned quiet_err;
    int unsigned k;
    for (int unsigned i = 0; i < DEPTH; i++) tab[i] = 16'hFFFF;
    tab[0] = 16'h1280; tab[1] = 16'hFFF0; tab[2] = 16'h1204; tab[3] = 16'h1100;
    tab[4] = 16'h0C00; tab[5] = 16'h3E00; tab[6] = 16'h4010;
`ifdef CAM_CFG_TEST_PATTERN_EN
    tab[7] = 16'h70BA; tab[8] = 16'h71B5;
`endif
    for (int unsigned i = 0; i < end_index(); i++)
      if (tab[i] != 16'hFFF0) wr_list.push_back({8'h42, tab[i]});

    // reset state
    repeat (3) @(negedge clk_i);
    chk("reset_sioc",  sioc_o,    1);
    chk("reset_oe",    siod_oe_o, 0);
    chk("reset_busy",  busy_o,    0);
    chk("reset_done",  done_o,    0);
    chk("reset_index", index_o,   0);
    #1 reset_i = 1'b0;

    // first transaction, cycle numbers counted from the first FETCH cycle (c0)
    pulse_start();
    chk("busy_after_start", busy_o, 1);
    chk("index_after_start", index_o, 0);
    @(negedge clk_i);                       // c1: START, SIOD low under SIOC high
    chk("start_sioc", sioc_o, 1);
    chk("start_oe", siod_oe_o, 1);
    repeat (112) @(negedge clk_i);          // c113: STOP quarter 0
    chk("stop_q0_sioc", sioc_o, 0);
    chk("stop_q0_oe", siod_oe_o, 1);
    repeat (3) @(negedge clk_i);            // c116: last STOP quarter
    chk("stop_q3_oe", siod_oe_o, 0);
    chk("first_write", (dec_q.size() > 0) ? dec_q[0] : 24'h0, 24'h421280);
    repeat (4) @(negedge clk_i);            // c120: last GAP cycle
    chk("gap_index", index_o, 0);
    @(negedge clk_i);                       // c121: FETCH of the delay entry
    chk("fetch_delay_index", index_o, 1);
    quiet_err = 0;
    repeat (40) begin @(negedge clk_i); if (sioc_o !== 1'b1) quiet_err++; end
    chk("delay_quiet", quiet_err, 0);       // c161
    chk("delay_index", index_o, 1);
    @(negedge clk_i);                       // c162
    chk("after_delay_index", index_o, 2);

    // start while busy is ignored
    repeat (38) @(negedge clk_i);
    pulse_start();
    chk("busy_start_index", index_o, 2);
    chk("busy_start_busy", busy_o, 1);

    wait_done("done_reached");
    chk("done_index", index_o, END_IDX);
    chk("write_count", wr_ptr, WR_CNT);

    // restart from DONE
    pulse_start();
    chk("restart_done", done_o, 0);
    chk("restart_index", index_o, 0);

    // reset while SIOD is driven and SIOC is low inside a phase
    repeat (20) @(negedge clk_i);
    k = 0;
    while (!(sioc_o === 1'b0 && siod_oe_o === 1'b1) && k < 40) begin @(negedge clk_i); k++; end
    chk("reset_point_found", (k < 40) ? 1 : 0, 1);
    hit_reset();
    pulse_start();
    chk("rerun_index", index_o, 0);
    chk("rerun_busy", busy_o, 1);

    // randomized starts and resets
    for (int unsigned it = 0; it < 8; it++) begin
      repeat ($urandom_range(1, 900)) @(negedge clk_i);
      if ($urandom_range(0, 3) == 0) hit_reset();
      else pulse_start();
    end
    if (busy_o !== 1'b1 && done_o !== 1'b1) pulse_start();
    wait_done("final_done");
    chk("final_index", index_o, END_IDX);
    chk("final_write_count", wr_ptr, WR_CNT);

    @(negedge clk_i);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
